// File: rtl/ddr5_bank_cmd_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// ddr5_bank_cmd_sequencer_pkg
// Shared types and constants for the DDR5 bank command sequencer:
//   - mapped_addr_t : mapped request address (bank group, bank, row, column)
//   - ddr_cmd_t     : command encoding presented to the trace writer
//   - seq_state_t   : sequencer FSM states
//   - bank index width and default timing constants (in clocks)
//   - small helpers for bank indexing and saturating timer decrement
// ----------------------------------------------------------------------------
package ddr5_bank_cmd_sequencer_pkg;

   localparam int BG_W       = 3;
   localparam int BANK_W     = 2;
   localparam int ROW_W      = 16;
   localparam int COL_W      = 10;
   localparam int BANK_IDX_W = 5;
   localparam int NUM_BANKS  = 32;
   localparam int TMR_W      = 8;

   localparam int unsigned T_RP_DEFAULT    = 32'd39;
   localparam int unsigned T_RCD_DEFAULT   = 32'd39;
   localparam int unsigned T_RAS_DEFAULT   = 32'd76;
   localparam int unsigned T_BURST_DEFAULT = 32'd8;

   localparam logic [TMR_W-1:0] TMR_ZERO = 8'd0;
   localparam logic [TMR_W-1:0] TMR_ONE  = 8'd1;

   // Mapped request address as delivered by the scheduler queue head
   typedef struct packed {
      logic [BG_W-1:0]   bg;
      logic [BANK_W-1:0] bank;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
   } mapped_addr_t;

   localparam mapped_addr_t ADDR_ZERO = '{bg: 3'd0, bank: 2'd0, row: 16'd0, col: 10'd0};

   typedef enum logic [2:0] {
      CMD_NOP  = 3'd0,
      CMD_PRE  = 3'd1,
      CMD_ACT0 = 3'd2,
      CMD_ACT1 = 3'd3,
      CMD_RD0  = 3'd4,
      CMD_RD1  = 3'd5,
      CMD_WR0  = 3'd6,
      CMD_WR1  = 3'd7
   } ddr_cmd_t;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_PRE_WAIT   = 4'd1,
      ST_RP_WAIT    = 4'd2,
      ST_ACT0       = 4'd3,
      ST_ACT1       = 4'd4,
      ST_RCD_WAIT   = 4'd5,
      ST_COL0       = 4'd6,
      ST_COL1       = 4'd7,
      ST_BURST_WAIT = 4'd8
   } seq_state_t;

   // Flat bank index used by the open-page table: {bank group, bank}
   function automatic logic [BANK_IDX_W-1:0] bank_index(input logic [BG_W-1:0] bg,
                                                         input logic [BANK_W-1:0] bank);
      return {bg, bank};
   endfunction

   // Down-count by one, holding at zero
   function automatic logic [TMR_W-1:0] sat_dec(input logic [TMR_W-1:0] v);
      return (v != TMR_ZERO) ? (v - TMR_ONE) : TMR_ZERO;
   endfunction

endpackage

// File: rtl/ddr5_bank_cmd_sequencer_bank_state_table.sv
// ----------------------------------------------------------------------------
// ddr5_bank_cmd_sequencer_bank_state_table
// Open-page state for all 32 banks: open bit, open row and tRAS counter.
// Ports:
//   clock_i, reset_i        : clock, synchronous active-high reset
//   tick_i                  : decrement every nonzero tRAS counter by one
//   lkp_idx_i               : lookup bank index
//   lkp_open_o/row_o/ras_o  : combinational lookup result
//   upd_act_i               : open bank upd_idx_i with upd_row_i, load tRAS
//   upd_pre_i               : close bank upd_idx_i
//   upd_idx_i, upd_row_i    : update target bank and row
// ----------------------------------------------------------------------------
module ddr5_bank_cmd_sequencer_bank_state_table
   import ddr5_bank_cmd_sequencer_pkg::*;
#(
   parameter int unsigned T_RAS = T_RAS_DEFAULT
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  tick_i,
   input  logic [BANK_IDX_W-1:0] lkp_idx_i,
   output logic                  lkp_open_o,
   output logic [ROW_W-1:0]      lkp_row_o,
   output logic [TMR_W-1:0]      lkp_ras_o,
   input  logic                  upd_act_i,
   input  logic                  upd_pre_i,
   input  logic [BANK_IDX_W-1:0] upd_idx_i,
   input  logic [ROW_W-1:0]      upd_row_i
);

   localparam logic [TMR_W-1:0] RAS_LOAD = TMR_W'(T_RAS);

   logic               open_q [NUM_BANKS];
   logic [ROW_W-1:0]   row_q  [NUM_BANKS];
   logic [TMR_W-1:0]   ras_q  [NUM_BANKS];

   assign lkp_open_o = open_q[lkp_idx_i];
   assign lkp_row_o  = row_q[lkp_idx_i];
   assign lkp_ras_o  = ras_q[lkp_idx_i];

   // Per-bank open bit, row and tRAS counter; an activate reload wins over the tick
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            open_q[i] <= 1'b0;
            row_q[i]  <= 16'd0;
            ras_q[i]  <= 8'd0;
         end
      end else begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            if (upd_act_i && (upd_idx_i == BANK_IDX_W'(i))) begin
               open_q[i] <= 1'b1;
               row_q[i]  <= upd_row_i;
               ras_q[i]  <= RAS_LOAD;
            end else begin
               if (upd_pre_i && (upd_idx_i == BANK_IDX_W'(i))) begin
                  open_q[i] <= 1'b0;
               end
               if (tick_i) begin
                  ras_q[i] <= sat_dec(ras_q[i]);
               end
            end
         end
      end
   end

endmodule

// File: rtl/ddr5_bank_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// ddr5_bank_cmd_sequencer
// Converts one decoded request at a time into PRE / ACT0 / ACT1 / RD0 / RD1
// or WR0 / WR1 commands, honouring tRP, tRCD, tRAS and burst occupancy, with
// an open-page row table covering all 32 banks.
// Ports:
//   clock_i, reset_i       : clock, synchronous active-high reset
//   req_valid_i/ready_o    : request handshake (ready only while idle)
//   req_op_i               : 1 = write, all other codes read
//   req_bg/bank/row/col_i  : mapped request address, latched at accept
//   cmd_valid_o, cmd_o     : issued command (NOP when not valid)
//   cmd_bg/bank/row/col_o  : address fields of the issued command
//   done_o                 : one-cycle completion pulse (first idle cycle)
//   busy_o                 : sequencer not idle
// All outputs except req_ready_o's reset gating are registered. The decode
// below therefore computes the command for the *next* cycle, and table and
// timer side effects are committed on the same edge, so they are visible in
// the cycle the command is on the bus.
// ----------------------------------------------------------------------------
module ddr5_bank_cmd_sequencer
   import ddr5_bank_cmd_sequencer_pkg::*;
#(
   parameter int unsigned T_RP    = T_RP_DEFAULT,
   parameter int unsigned T_RCD   = T_RCD_DEFAULT,
   parameter int unsigned T_RAS   = T_RAS_DEFAULT,
   parameter int unsigned T_BURST = T_BURST_DEFAULT
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_op_i,
   input  logic [BG_W-1:0]   req_bg_i,
   input  logic [BANK_W-1:0] req_bank_i,
   input  logic [ROW_W-1:0]  req_row_i,
   input  logic [COL_W-1:0]  req_col_i,
   output logic              cmd_valid_o,
   output logic [2:0]        cmd_o,
   output logic [BG_W-1:0]   cmd_bg_o,
   output logic [BANK_W-1:0] cmd_bank_o,
   output logic [ROW_W-1:0]  cmd_row_o,
   output logic [COL_W-1:0]  cmd_col_o,
   output logic              done_o,
   output logic              busy_o
);

   localparam logic [TMR_W-1:0] RP_LOAD    = TMR_W'(T_RP - 1);
   localparam logic [TMR_W-1:0] RCD_LOAD   = TMR_W'(T_RCD - 1);
   localparam logic [TMR_W-1:0] BURST_LOAD = TMR_W'(T_BURST - 1);

   seq_state_t             state_q, state_d;
   ddr_cmd_t               cmd_q, cmd_d;
   mapped_addr_t           lat_q, lat_d;
   logic                   wr_q, wr_d;
   logic [TMR_W-1:0]       timer_q, timer_d;
   logic                   done_q, done_d;
   logic                   ready_q, busy_q, cmd_valid_q;
   logic [BG_W-1:0]        cmd_bg_q;
   logic [BANK_W-1:0]      cmd_bank_q;
   logic [ROW_W-1:0]       cmd_row_q;
   logic [COL_W-1:0]       cmd_col_q;

   logic [BANK_IDX_W-1:0]  bank_idx_s;
   logic                   lkp_open_s;
   logic [ROW_W-1:0]       lkp_row_s;
   logic [TMR_W-1:0]       lkp_ras_s;
   logic [TMR_W-1:0]       ras_next_s;
   logic                   upd_act_s, upd_pre_s;
   logic                   req_wr_s;

   // While idle the table is probed with the incoming request so it can be
   // classified in the accept cycle; afterwards the latched bank is used.
   assign bank_idx_s = (state_q == ST_IDLE) ? bank_index(req_bg_i, req_bank_i)
                                            : bank_index(lat_q.bg, lat_q.bank);
   // tRAS value the bank will hold next cycle, i.e. when a PRE decided now issues
   assign ras_next_s = sat_dec(lkp_ras_s);
   assign req_wr_s   = (req_op_i == 2'd1);

   ddr5_bank_cmd_sequencer_bank_state_table #(
      .T_RAS (T_RAS)
   ) u_bank_state_table (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .tick_i     (1'b1),
      .lkp_idx_i  (bank_idx_s),
      .lkp_open_o (lkp_open_s),
      .lkp_row_o  (lkp_row_s),
      .lkp_ras_o  (lkp_ras_s),
      .upd_act_i  (upd_act_s),
      .upd_pre_i  (upd_pre_s),
      .upd_idx_i  (bank_idx_s),
      .upd_row_i  (lat_q.row)
   );

   // Next state, next-cycle command, timer reloads and table updates
   always_comb begin
      state_d   = state_q;
      cmd_d     = CMD_NOP;
      done_d    = 1'b0;
      timer_d   = sat_dec(timer_q);
      lat_d     = lat_q;
      wr_d      = wr_q;
      upd_act_s = 1'b0;
      upd_pre_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               lat_d = '{bg: req_bg_i, bank: req_bank_i, row: req_row_i, col: req_col_i};
               wr_d  = req_wr_s;
               if (!lkp_open_s) begin
                  state_d = ST_ACT0;
                  cmd_d   = CMD_ACT0;
               end else if (lkp_row_s == req_row_i) begin
                  state_d = ST_COL0;
                  cmd_d   = req_wr_s ? CMD_WR0 : CMD_RD0;
               end else begin
                  state_d = ST_PRE_WAIT;
                  if (ras_next_s == TMR_ZERO) begin
                     cmd_d     = CMD_PRE;
                     upd_pre_s = 1'b1;
                     timer_d   = RP_LOAD;
                  end else begin
                     cmd_d = CMD_NOP;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRE_WAIT: begin
            // cmd_q == PRE marks the cycle the precharge is on the bus
            if (cmd_q == CMD_PRE) begin
               if (timer_q == TMR_ZERO) begin
                  state_d = ST_ACT0;
                  cmd_d   = CMD_ACT0;
               end else begin
                  state_d = ST_RP_WAIT;
               end
            end else if (ras_next_s == TMR_ZERO) begin
               cmd_d     = CMD_PRE;
               upd_pre_s = 1'b1;
               timer_d   = RP_LOAD;
            end else begin
               state_d = ST_PRE_WAIT;
            end
         end
         ST_RP_WAIT: begin
            if (timer_q == TMR_ZERO) begin
               state_d = ST_ACT0;
               cmd_d   = CMD_ACT0;
            end else begin
               state_d = ST_RP_WAIT;
            end
         end
         ST_ACT0: begin
            state_d   = ST_ACT1;
            cmd_d     = CMD_ACT1;
            upd_act_s = 1'b1;
            timer_d   = RCD_LOAD;
         end
         ST_ACT1, ST_RCD_WAIT: begin
            if (timer_q == TMR_ZERO) begin
               state_d = ST_COL0;
               cmd_d   = wr_q ? CMD_WR0 : CMD_RD0;
            end else begin
               state_d = ST_RCD_WAIT;
            end
         end
         ST_COL0: begin
            state_d = ST_COL1;
            cmd_d   = wr_q ? CMD_WR1 : CMD_RD1;
            timer_d = BURST_LOAD;
         end
         ST_COL1, ST_BURST_WAIT: begin
            if (timer_q == TMR_ZERO) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_BURST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched request, timer and registered output stage
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cmd_q       <= CMD_NOP;
         lat_q       <= ADDR_ZERO;
         wr_q        <= 1'b0;
         timer_q     <= 8'd0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_bg_q    <= 3'd0;
         cmd_bank_q  <= 2'd0;
         cmd_row_q   <= 16'd0;
         cmd_col_q   <= 10'd0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         lat_q       <= lat_d;
         wr_q        <= wr_d;
         timer_q     <= timer_d;
         done_q      <= done_d;
         ready_q     <= (state_d == ST_IDLE);
         busy_q      <= (state_d != ST_IDLE);
         cmd_valid_q <= (cmd_d != CMD_NOP);
         cmd_bg_q    <= (cmd_d != CMD_NOP) ? lat_d.bg   : 3'd0;
         cmd_bank_q  <= (cmd_d != CMD_NOP) ? lat_d.bank : 2'd0;
         cmd_row_q   <= (cmd_d != CMD_NOP) ? lat_d.row  : 16'd0;
         cmd_col_q   <= (cmd_d != CMD_NOP) ? lat_d.col  : 10'd0;
      end
   end

   assign req_ready_o = ready_q & ~reset_i;
   assign cmd_valid_o = cmd_valid_q;
   assign cmd_o       = cmd_q;
   assign cmd_bg_o    = cmd_bg_q;
   assign cmd_bank_o  = cmd_bank_q;
   assign cmd_row_o   = cmd_row_q;
   assign cmd_col_o   = cmd_col_q;
   assign done_o      = done_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_ddr5_bank_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ddr5_bank_cmd_sequencer
// Scoreboard bench: every accepted request pushes its expected command and
// done events (with their cycle numbers) into a queue; a monitor pops and
// compares each event the sequencer produces.
// ----------------------------------------------------------------------------
module tb_ddr5_bank_cmd_sequencer;

   localparam int T_RP    = 39;
   localparam int T_RCD   = 39;
   localparam int T_RAS   = 76;
   localparam int T_BURST = 8;

   localparam logic [3:0] E_PRE  = 4'd1;
   localparam logic [3:0] E_ACT0 = 4'd2;
   localparam logic [3:0] E_ACT1 = 4'd3;
   localparam logic [3:0] E_RD0  = 4'd4;
   localparam logic [3:0] E_RD1  = 4'd5;
   localparam logic [3:0] E_WR0  = 4'd6;
   localparam logic [3:0] E_WR1  = 4'd7;
   localparam logic [3:0] E_DONE = 4'd8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [1:0]  req_op = 2'd0;
   logic [2:0]  req_bg = 3'd0;
   logic [1:0]  req_bank = 2'd0;
   logic [15:0] req_row = 16'd0;
   logic [9:0]  req_col = 10'd0;
   logic        req_ready_o, cmd_valid_o, done_o, busy_o;
   logic [2:0]  cmd_o, cmd_bg_o;
   logic [1:0]  cmd_bank_o;
   logic [15:0] cmd_row_o;
   logic [9:0]  cmd_col_o;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      int          t;
      logic [3:0]  kind;
      logic [2:0]  bg;
      logic [1:0]  bank;
      logic [15:0] row;
      logic [9:0]  col;
   } ev_t;
   ev_t exp_q[$];

   bit          bm_open [32];
   logic [15:0] bm_row  [32];
   int          bm_act1 [32];

   ddr5_bank_cmd_sequencer #(
      .T_RP(T_RP), .T_RCD(T_RCD), .T_RAS(T_RAS), .T_BURST(T_BURST)
   ) dut (
      .clock_i(clock), .reset_i(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o),
      .req_op_i(req_op), .req_bg_i(req_bg), .req_bank_i(req_bank),
      .req_row_i(req_row), .req_col_i(req_col),
      .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .cmd_bg_o(cmd_bg_o),
      .cmd_bank_o(cmd_bank_o), .cmd_row_o(cmd_row_o), .cmd_col_o(cmd_col_o),
      .done_o(done_o), .busy_o(busy_o)
   );

   always #5 clock = ~clock;

   // Cycle number: value seen during a cycle, bumped at each rising edge
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_ev(input int t, input logic [3:0] kind, input logic [2:0] bg,
                          input logic [1:0] bank, input logic [15:0] row, input logic [9:0] col);
      ev_t e;
      e.t = t; e.kind = kind; e.bg = bg; e.bank = bank; e.row = row; e.col = col;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         bm_open[i] = 1'b0; bm_row[i] = 16'd0; bm_act1[i] = 0;
      end
   endtask

   // Expected command timeline for a request accepted in cycle acc
   task automatic model_req(input int acc, input logic [1:0] op, input logic [2:0] bg,
                            input logic [1:0] bank, input logic [15:0] row,
                            input logic [9:0] col, input bit partial);
      int idx, pre, act0, col0;
      bit wr;
      idx = int'({bg, bank});
      wr  = (op == 2'd1);
      if (bm_open[idx] && bm_row[idx] == row) begin
         col0 = acc + 1;
      end else begin
         act0 = acc + 1;
         if (bm_open[idx]) begin
            pre = bm_act1[idx] + T_RAS;
            if (pre < acc + 1) pre = acc + 1;
            push_ev(pre, E_PRE, bg, bank, row, col);
            act0 = pre + T_RP;
         end
         push_ev(act0, E_ACT0, bg, bank, row, col);
         push_ev(act0 + 1, E_ACT1, bg, bank, row, col);
         bm_open[idx] = 1'b1; bm_row[idx] = row; bm_act1[idx] = act0 + 1;
         col0 = act0 + 1 + T_RCD;
      end
      if (!partial) begin
         push_ev(col0, wr ? E_WR0 : E_RD0, bg, bank, row, col);
         push_ev(col0 + 1, wr ? E_WR1 : E_RD1, bg, bank, row, col);
         push_ev(col0 + 1 + T_BURST, E_DONE, bg, bank, row, col);
      end
   endtask

   // Wait for ready, present one request for exactly one accepting edge
   task automatic send(input logic [1:0] op, input logic [2:0] bg, input logic [1:0] bank,
                       input logic [15:0] row, input logic [9:0] col, input bit partial,
                       output int acc);
      int n;
      n = 0;
      while (!req_ready_o && n < 1000) begin
         @(posedge clock); #1;
         n++;
      end
      check("req_ready_wait", 64'(req_ready_o), 64'd1);
      req_valid = 1'b1; req_op = op; req_bg = bg; req_bank = bank;
      req_row = row; req_col = col;
      acc = cyc;
      model_req(acc, op, bg, bank, row, col, partial);
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   // Scoreboard monitor, sampled mid-cycle on the falling edge
   always @(negedge clock) begin
      ev_t e;
      if (!cmd_valid_o && cmd_o != 3'd0) check("nop_when_invalid", 64'(cmd_o), 64'd0);
      if (cmd_valid_o || done_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", 64'({cmd_valid_o, cmd_o, done_o}), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("event_kind", 64'(done_o ? E_DONE : {1'b0, cmd_o}), 64'(e.kind));
            check("event_cycle", 64'(cyc), 64'(e.t));
            if (!done_o) begin
               check("cmd_bg_bank", 64'({cmd_bg_o, cmd_bank_o}), 64'({e.bg, e.bank}));
               if (e.kind == E_ACT0 || e.kind == E_ACT1)
                  check("cmd_row", 64'(cmd_row_o), 64'(e.row));
               if (e.kind >= E_RD0 && e.kind <= E_WR1)
                  check("cmd_col", 64'(cmd_col_o), 64'(e.col));
            end
         end
      end
   end

   initial begin
      int a1, a2, a3, ax, phase, n;
      model_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
      check("rst_cmd", 64'(cmd_o), 64'd0);
      check("rst_fields", 64'({cmd_bg_o, cmd_bank_o, cmd_row_o, cmd_col_o}), 64'd0);
      check("rst_busy_done", 64'({busy_o, done_o}), 64'd0);
      check("rst_ready_low", 64'(req_ready_o), 64'd0);
      reset = 1'b0;
      #1;
      check("ready_after_rst", 64'(req_ready_o), 64'd1);

      // Empty bank read, page hit read, then a write miss held by tRAS
      send(2'd0, 3'd2, 2'd1, 16'h1234, 10'h03F, 1'b0, a1);
      send(2'd0, 3'd2, 2'd1, 16'h1234, 10'h040, 1'b0, a2);
      check("hit_accept_in_done_cycle", 64'(a2 - a1), 64'd50);
      send(2'd1, 3'd2, 2'd1, 16'h0100, 10'h0AA, 1'b0, a3);
      check("miss_accept_in_done_cycle", 64'(a3 - a2), 64'd10);

      // Fetch to a closed bank leaves bg2/b1 open; reserved op reads
      send(2'd2, 3'd7, 2'd3, 16'h7777, 10'h155, 1'b0, ax);
      send(2'd0, 3'd2, 2'd1, 16'h0100, 10'h2AA, 1'b0, ax);
      send(2'd3, 3'd7, 2'd3, 16'h7777, 10'h001, 1'b0, ax);

      // req_valid held high with changing fields while busy
      send(2'd1, 3'd1, 2'd0, 16'h0055, 10'h011, 1'b0, ax);
      phase = 0;
      for (int k = 0; k < 600 && phase < 2; k++) begin
         if (busy_o) begin
            check("ready_low_while_busy", 64'(req_ready_o), 64'd0);
            req_valid = 1'b1;
            req_op    = 2'($urandom_range(3, 0));
            req_bg    = 3'($urandom_range(7, 0));
            req_bank  = 2'($urandom_range(3, 0));
            req_row   = 16'($urandom_range(65535, 0));
            req_col   = 10'($urandom_range(1023, 0));
         end else if (phase == 0) begin
            check("ready_in_done_cycle", 64'(req_ready_o), 64'd1);
            req_valid = 1'b1; req_op = 2'd0; req_bg = 3'd1; req_bank = 2'd0;
            req_row = 16'h0055; req_col = 10'h022;
            model_req(cyc, 2'd0, 3'd1, 2'd0, 16'h0055, 10'h022, 1'b0);
            phase = 1;
         end else begin
            req_valid = 1'b0;
            phase = 2;
         end
         @(posedge clock); #1;
      end
      req_valid = 1'b0;
      check("busy_stream_completed", 64'(phase), 64'd2);

      // Miss whose tRAS has long expired precharges immediately
      send(2'd0, 3'd2, 2'd1, 16'h0200, 10'h033, 1'b0, ax);

      // Reset in RCD_WAIT abandons the sequence and closes every bank
      send(2'd0, 3'd4, 2'd2, 16'h0ABC, 10'h0CD, 1'b1, ax);
      repeat (9) @(posedge clock);
      #1;
      check("busy_before_mid_reset", 64'(busy_o), 64'd1);
      reset = 1'b1;
      @(posedge clock); #1;
      check("mid_reset_cmd_valid", 64'(cmd_valid_o), 64'd0);
      check("mid_reset_busy_done", 64'({busy_o, done_o}), 64'd0);
      reset = 1'b0;
      model_reset();
      @(posedge clock); #1;
      send(2'd0, 3'd4, 2'd2, 16'h0ABC, 10'h0CE, 1'b0, ax);
      send(2'd0, 3'd2, 2'd1, 16'h0200, 10'h034, 1'b0, ax);

      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clock); #1;
         n++;
      end
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      repeat (5) @(posedge clock);
      #1;
      check("idle_at_end", 64'({busy_o, req_ready_o}), 64'b01);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
